// File: rtl/midi_event_tx.sv
// MIDI note-on/note-off transmitter: one event becomes a 2- or 3-byte 8N1
// message on serial_tx, with optional running-status suppression.
module midi_event_tx #(
    parameter int CLK_FREQ       = 16000000,
    parameter int BAUD           = 31250,
    parameter int RUNNING_STATUS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ev_valid,
    output logic       ev_ready,
    input  logic       ev_note_on,
    input  logic [3:0] ev_channel,
    input  logic [6:0] ev_note,
    input  logic [6:0] ev_velocity,
    input  logic       rs_flush,
    output logic       serial_tx,
    output logic       busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, SEND_STATUS, SEND_D1, SEND_D2} state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    cur_byte;
    logic [7:0]    d1_byte;
    logic [7:0]    d2_byte;
    logic [7:0]    rs_byte;
    logic          rs_valid;
    logic [7:0]    new_status;
    logic          skip_status;

    assign new_status  = {(ev_note_on ? 4'h9 : 4'h8), ev_channel};
    // A flush on the accepting edge forces the status byte out.
    assign skip_status = (RUNNING_STATUS != 0) && rs_valid && !rs_flush &&
                         (rs_byte == new_status);
    assign busy        = ~ev_ready;

    // Line level for frame position idx: 0 start, 1..8 data LSB first, 9 stop.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
        logic [3:0] j;
        j = idx - 4'd1;
        if (idx == 4'd0)
            return 1'b0;
        else if (idx >= 4'd9)
            return 1'b1;
        else
            return b[j[2:0]];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ev_ready  <= 1'b1;
            serial_tx <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            cur_byte  <= '0;
            d1_byte   <= '0;
            d2_byte   <= '0;
            rs_byte   <= '0;
            rs_valid  <= 1'b0;
        end else begin
            if (rs_flush)
                rs_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ev_valid) begin
                        d1_byte   <= {1'b0, ev_note};
                        d2_byte   <= {1'b0, ev_velocity};
                        serial_tx <= 1'b0;
                        baud_cnt  <= '0;
                        bit_idx   <= '0;
                        ev_ready  <= 1'b0;
                        if (skip_status) begin
                            state    <= SEND_D1;
                            cur_byte <= {1'b0, ev_note};
                        end else begin
                            state    <= SEND_STATUS;
                            cur_byte <= new_status;
                            rs_byte  <= new_status;
                            rs_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (baud_cnt != CNT_MAX) begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end else begin
                        baud_cnt <= '0;
                        if (bit_idx != 4'd9) begin
                            bit_idx   <= bit_idx + 4'd1;
                            serial_tx <= frame_bit(cur_byte, bit_idx + 4'd1);
                        end else begin
                            // Stop bit done: chain the next start bit with no gap.
                            bit_idx <= '0;
                            case (state)
                                SEND_STATUS: begin
                                    state     <= SEND_D1;
                                    cur_byte  <= d1_byte;
                                    serial_tx <= 1'b0;
                                end
                                SEND_D1: begin
                                    state     <= SEND_D2;
                                    cur_byte  <= d2_byte;
                                    serial_tx <= 1'b0;
                                end
                                default: begin
                                    state     <= IDLE;
                                    ev_ready  <= 1'b1;
                                    serial_tx <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end
endmodule
